// File: rtl/tx_frame_modulator_pkg.sv
// ============================================================================
// Module      : tx_frame_modulator_pkg
// Description : Shared tx/rx definitions: frame defaults, symbol/alpha widths,
//               FSM state encoding and the bit-to-amplitude mapper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tx_frame_modulator_pkg;

    localparam int c_N_DEF      = 128;
    localparam int c_STRIDE_DEF = 37;
    localparam int c_OFFSET_DEF = 0;
    localparam int c_AMP_I_DEF  = 3;
    localparam int c_AMP_Q_DEF  = 1;
    localparam int c_SYM_W      = 4;
    localparam int c_ALPHA_W    = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } tx_state_t;

    // A set bit maps to +amp, a clear bit to -amp in two's complement.
    function automatic logic [c_SYM_W-1:0] map_sym(input logic b, input logic [c_SYM_W-1:0] amp);
        return b ? amp : -amp;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tx_frame_modulator_if.sv
// ============================================================================
// Module      : tx_frame_modulator_if
// Description : Frame-in / symbol-out handshake bundle of the tx modulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tx_frame_modulator_if
    import tx_frame_modulator_pkg::*;
#(
    parameter int N = c_N_DEF
);

    logic [N-1:0]           frame_data;
    logic                   frame_valid;
    logic                   frame_ready;
    logic [c_SYM_W-1:0]     i_out;
    logic [c_SYM_W-1:0]     q_out;
    logic [c_ALPHA_W-1:0]   alpha_sym;
    logic                   sym_valid;
    logic                   sym_ready;
    logic                   frame_done;

    modport master (
        output frame_data, frame_valid, sym_ready,
        input  frame_ready, i_out, q_out, alpha_sym, sym_valid, frame_done
    );

    modport slave (
        input  frame_data, frame_valid, sym_ready,
        output frame_ready, i_out, q_out, alpha_sym, sym_valid, frame_done
    );

endinterface

`default_nettype wire

// File: rtl/tx_perm_gen.sv
// ============================================================================
// Module      : tx_perm_gen
// Description : Modular-stride interleaver address generator with symbol
//               counter; alpha is the address of the symbol loaded this cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tx_perm_gen #(
    parameter int N      = 128,
    parameter int STRIDE = 37,
    parameter int OFFSET = 0,
    localparam int AW    = $clog2(N)
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          load,
    input  wire logic          advance,
    output logic [AW-1:0]      alpha,
    output logic               last
);

    localparam logic [AW-1:0] c_STRIDE = AW'(STRIDE);
    localparam logic [AW-1:0] c_OFFSET = AW'(OFFSET);
    localparam logic [AW-1:0] c_LAST   = AW'(N - 1);

    logic [AW-1:0] r_alpha;
    logic [AW-1:0] r_k;
    logic [AW-1:0] w_alpha_adv;

    // N is a power of two, so the AW-bit add wraps exactly modulo N.
    assign w_alpha_adv = r_alpha + c_STRIDE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alpha <= '0;
            r_k     <= '0;
        end else if (load) begin
            r_alpha <= c_OFFSET;
            r_k     <= '0;
        end else if (advance) begin
            r_alpha <= w_alpha_adv;
            r_k     <= r_k + AW'(1);
        end
    end

    assign alpha = load ? c_OFFSET : (advance ? w_alpha_adv : r_alpha);
    assign last  = (r_k == c_LAST);

endmodule

`default_nettype wire

// File: rtl/tx_frame_modulator.sv
// ============================================================================
// Module      : tx_frame_modulator
// Description : Latches an N-bit frame, interleaves it and emits one signed
//               4-bit I/Q symbol per bit, tagged with its interleaver address.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tx_frame_modulator
    import tx_frame_modulator_pkg::*;
#(
    parameter int N      = c_N_DEF,
    parameter int STRIDE = c_STRIDE_DEF,
    parameter int OFFSET = c_OFFSET_DEF,
    parameter int AMP_I  = c_AMP_I_DEF,
    parameter int AMP_Q  = c_AMP_Q_DEF
) (
    input  wire logic              clk,
    input  wire logic              rst,
    tx_frame_modulator_if.slave    bus
);

    localparam int               c_AW    = $clog2(N);
    localparam logic [c_SYM_W-1:0] c_AMP_I = c_SYM_W'(AMP_I);
    localparam logic [c_SYM_W-1:0] c_AMP_Q = c_SYM_W'(AMP_Q);

    tx_state_t              r_state;
    tx_state_t              w_state_next;
    logic                   w_frame_ready;
    logic                   w_accept;
    logic                   w_xfer;
    logic                   w_bit;
    logic                   w_last;
    logic [c_AW-1:0]        w_alpha;
    logic [N-1:0]           r_frame;
    logic                   r_sym_valid;
    logic                   r_frame_done;
    logic [c_SYM_W-1:0]     r_i;
    logic [c_SYM_W-1:0]     r_q;
    logic [c_ALPHA_W-1:0]   r_alpha_sym;

    assign w_accept = w_frame_ready && bus.frame_valid;
    assign w_xfer   = r_sym_valid && bus.sym_ready;

    tx_perm_gen #(
        .N      (N),
        .STRIDE (STRIDE),
        .OFFSET (OFFSET)
    ) u_perm (
        .clk     (clk),
        .rst     (rst),
        .load    (w_accept),
        .advance (w_xfer),
        .alpha   (w_alpha),
        .last    (w_last)
    );

    // Symbol 0 is taken straight from the input bus on the accept edge.
    assign w_bit = w_accept ? bus.frame_data[w_alpha] : r_frame[w_alpha];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_frame_ready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_frame_ready = 1'b1;
                if (bus.frame_valid) begin
                    w_state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                if (w_xfer && w_last) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame      <= '0;
            r_sym_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_i          <= '0;
            r_q          <= '0;
            r_alpha_sym  <= '0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_accept || (w_xfer && !w_last)) begin
                r_sym_valid <= 1'b1;
                r_i         <= map_sym(w_bit, c_AMP_I);
                r_q         <= map_sym(w_bit, c_AMP_Q);
                r_alpha_sym <= c_ALPHA_W'(w_alpha);
            end else if (w_xfer) begin
                r_sym_valid  <= 1'b0;
                r_frame_done <= 1'b1;
            end
            if (w_accept) begin
                r_frame <= bus.frame_data;
            end
        end
    end

    assign bus.frame_ready = w_frame_ready;
    assign bus.sym_valid   = r_sym_valid;
    assign bus.frame_done  = r_frame_done;
    assign bus.i_out       = r_i;
    assign bus.q_out       = r_q;
    assign bus.alpha_sym   = r_alpha_sym;

endmodule

`default_nettype wire

// File: doc/tx_frame_modulator.md
Name: tx_frame_modulator

Overview:
- Transmit-side counterpart of the soft-demod/de-interleave/decode receive chain.
- Accepts one N-bit information frame, interleaves it with a modular-stride permutation, and maps one bit per symbol onto a signed 4-bit I/Q pair.
- Each output symbol is tagged with its interleaver address (alpha_sym), so the receive de-interleaver writes it back to its original bit position.
- Sits between the frame source (PS/DMA or test pattern) and the DAC/symbol link.

Parameters:
- N, 128, symbols (= bits) per frame; power of 2, 2..256.
- STRIDE, 37, interleaver stride; odd, less than N (odd guarantees a bijection).
- OFFSET, 0, interleaver start address; less than N.
- AMP_I, 3, I magnitude (signed 4-bit, 1..7).
- AMP_Q, 1, Q magnitude (signed 4-bit, 0..7).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- frame_data  in  N  information bits; bit j = bit position j
- frame_valid  in  1  frame_data valid
- frame_ready  out  1  block idle, frame can be accepted
- i_out  out  4  signed I symbol
- q_out  out  4  signed Q symbol
- alpha_sym  out  8  original bit index carried by this symbol
- sym_valid  out  1  symbol outputs valid
- sym_ready  in  1  downstream accepts symbol; tie to 1 for the receive link, which has no backpressure
- frame_done  out  1  one-cycle pulse after the last symbol transfers

Behaviour:
- Reset (async assert, sync-release domain handled upstream) forces:
  - state = IDLE, frame_ready = 1, sym_valid = 0, frame_done = 0
  - i_out = 0, q_out = 0, alpha_sym = 0, symbol counter = 0, frame register = 0
- State machine: IDLE, SEND.
  - IDLE: frame_ready = 1. When frame_valid && frame_ready at edge T:
    - latch frame_data
    - alpha = OFFSET, k = 0
    - go to SEND
    - present symbol 0 registered, so sym_valid = 1 from T+1
  - SEND: frame_ready = 0. A transfer happens when sym_valid && sym_ready. On each transfer:
    - k <= k+1
    - alpha <= (alpha + STRIDE) mod N, computed in log2(N) bits with natural wrap (no divider)
    - next symbol registered
  - If the transfer has k = N-1:
    - next cycle sym_valid = 0, frame_done = 1 (one cycle)
    - state = IDLE, frame_ready = 1
  - Minimum gap between frames is one idle cycle.
- Symbol k mapping:
  - bit b = frame_reg[alpha_k]
  - i_out = b ? +AMP_I : -AMP_I
  - q_out = b ? +AMP_Q : -AMP_Q (two's complement)
  - alpha_sym = zero-extended alpha_k
- Backpressure: while sym_valid && !sym_ready, i_out/q_out/alpha_sym/sym_valid hold stable; k and alpha do not advance.
- Throughput: one symbol per cycle with sym_ready = 1. Frame occupies N cycles plus one idle cycle.
- frame_valid during SEND: ignored and not latched. The source holds it until frame_ready.
- Reset mid-frame: outputs clear immediately. After release, the next accepted frame restarts at k = 0, alpha = OFFSET. The partial frame is discarded and no frame_done is issued.
- frame_data may change after acceptance without effect.

Decomposition:
- Shared include (tx/rx defs), used by both TX and RX tops:
  - N default
  - STRIDE and OFFSET defaults
  - AMP_I and AMP_Q constants
  - symbol width (4) and alpha width (8)
- Sub-module tx_perm_gen:
  - load/advance inputs, wrap-add address register and symbol counter
  - outputs alpha and a last flag
  - reusable later for an address generator on the RX side

Test Plan:
- Frame all-ones, sym_ready = 1 -> 128 consecutive symbols with i_out = 4'b0011, q_out = 4'b0001; frame_done pulses exactly 1 cycle after symbol 127; frame_ready returns high the same cycle.
- Frame 128'h1 -> only the symbol with alpha_sym = 0 (k = 0) has i_out = +3; all other symbols have i_out = 4'b1101 (-3), q_out = 4'b1111 (-1).
- Address check, STRIDE = 37, OFFSET = 0:
  - alpha_sym for k = 0..4 is 0, 37, 74, 111, 20
  - all 128 alpha_sym values are distinct, so they cover 0..127
- Backpressure: drop sym_ready for 5 cycles while k = 10 is presented -> alpha_sym holds 114 with i/q stable. The symbol count still reaches exactly 128, with no duplicates or loss.
- frame_valid held during SEND with different data -> not accepted; the second frame starts only after frame_done. Its symbol 0 shows the new data.
- Assert rst at k = 50 -> sym_valid = 0 in the same cycle, with no frame_done. After release, a new frame emits k = 0 with alpha_sym = 0.
